// File: rtl/vrev_pkg.sv
// Shared types and helpers for the bit-reversal sharing arbiter.
package vrev_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  function automatic int id_w(input int n);
    return $clog2(n);
  endfunction

  function automatic logic [DEF_DATA_W-1:0] bit_rev(input logic [DEF_DATA_W-1:0] d);
    logic [DEF_DATA_W-1:0] r;
    for (int i = 0; i < DEF_DATA_W; i++) r[i] = d[DEF_DATA_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/bit_reverse_unit.sv
// Purely combinational bit reversal: dout[i] = din[W-1-i].
module bit_reverse_unit #(
  parameter int W = 8
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  for (genvar i = 0; i < W; i++) begin : g_rev
    assign dout[i] = din[W-1-i];
  end

endmodule

// File: rtl/vrev_share_arbiter.sv
// Round-robin share of one bit-reversal datapath among NUM_REQ valid/ready
// requesters, with a single registered, id-tagged response slot.
module vrev_share_arbiter
  import vrev_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int CNT_W   = 16,
  localparam int ID_W    = id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  input  logic                      rsp_ready,
  output logic                      busy,
  output logic [CNT_W-1:0]          xfer_cnt
);

  slot_e            slot;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_found;
  logic             can_accept;
  logic             accept;
  int               cand;
  logic [DATA_W-1:0] req_words [NUM_REQ];
  logic [DATA_W-1:0] rev_out;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_words[k] = req_data[k*DATA_W +: DATA_W];
  end

  assign rsp_valid  = (slot == SLOT_FULL);
  assign can_accept = !rsp_valid || rsp_ready;
  assign accept     = grant_found && can_accept;
  assign busy       = rsp_valid || (|req_valid);

  // Search starts one past the last winner so the previous grantee goes last.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, otherwise a latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_REQ;
      if (!grant_found && req_valid[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  bit_reverse_unit #(.W(DATA_W)) u_rev (
    .din  (req_words[grant_idx]),
    .dout (rev_out)
  );

  // An accept overrides a drain in the same cycle, keeping the slot FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      slot     <= SLOT_EMPTY;
      rsp_data <= '0;
      rsp_id   <= '0;
      rr_ptr   <= ID_W'(NUM_REQ-1);
      xfer_cnt <= '0;
    end else if (accept) begin
      slot     <= SLOT_FULL;
      rsp_data <= rev_out;
      rsp_id   <= grant_idx;
      rr_ptr   <= grant_idx;
      if (xfer_cnt != '1) xfer_cnt <= xfer_cnt + 1'b1;
    end else if (rsp_valid && rsp_ready) begin
      slot <= SLOT_EMPTY;
    end
  end

endmodule

// File: tb/tb_vrev_share_arbiter.sv
// Randomized and directed bench for vrev_share_arbiter against a behavioural model.
module tb_vrev_share_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic            rsp_ready;

  logic [NREQ-1:0] req_ready,  req_ready_s;
  logic            rsp_valid,  rsp_valid_s;
  logic [DW-1:0]   rsp_data,   rsp_data_s;
  logic [1:0]      rsp_id,     rsp_id_s;
  logic            busy,       busy_s;
  logic [15:0]     xfer_cnt;
  logic [3:0]      xfer_cnt_s;

  vrev_share_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready), .busy(busy), .xfer_cnt(xfer_cnt)
  );

  // Narrow-counter build sharing the same stimulus, for saturation.
  vrev_share_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_s), .rsp_valid(rsp_valid_s), .rsp_data(rsp_data_s),
    .rsp_id(rsp_id_s), .rsp_ready(rsp_ready), .busy(busy_s), .xfer_cnt(xfer_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int            m_ptr;
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_id;
  int            m_cnt;
  logic [NREQ-1:0] last_acc;
  int            waitc [NREQ];
  int            max_wait;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rev8(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = d[DW-1-i];
    return r;
  endfunction

  function automatic logic [DW-1:0] word_of(input logic [NREQ*DW-1:0] d, input int k);
    return d[k*DW +: DW];
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_data   = '0;
    m_id     = 0;
    m_ptr    = NREQ-1;
    m_cnt    = 0;
    last_acc = '0;
    for (int k = 0; k < NREQ; k++) waitc[k] = 0;
  endtask

  // One clock: check combinational outputs before the edge, then registered ones after.
  task automatic step();
    int g;
    bit can;
    logic [NREQ-1:0] exp_rdy;
    logic [DW-1:0] gdata;
    #1;
    can = !m_valid || rsp_ready;
    g = -1;
    for (int i = 1; i <= NREQ; i++) begin
      int k;
      k = (m_ptr + i) % NREQ;
      if (g < 0 && req_valid[k]) g = k;
    end
    exp_rdy = '0;
    gdata   = '0;
    if (g >= 0 && can) begin
      exp_rdy[g] = 1'b1;
      gdata = word_of(req_data, g);
    end
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("req_ready_s", 32'(req_ready_s), 32'(exp_rdy));
    check("busy", 32'(busy), 32'(m_valid || (|req_valid)));
    last_acc = req_valid & exp_rdy;
    @(posedge clk);
    if (g >= 0 && can) begin
      for (int k = 0; k < NREQ; k++) begin
        if (k == g || !req_valid[k]) waitc[k] = 0;
        else begin
          waitc[k]++;
          if (waitc[k] > max_wait) max_wait = waitc[k];
        end
      end
      m_valid = 1'b1;
      m_data  = rev8(gdata);
      m_id    = g;
      m_ptr   = g;
      m_cnt++;
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check("rsp_data", 32'(rsp_data), 32'(m_data));
    check("rsp_id", 32'(rsp_id), 32'(m_id));
    check("xfer_cnt", 32'(xfer_cnt), 32'((m_cnt > 65535) ? 65535 : m_cnt));
    check("rsp_valid_s", 32'(rsp_valid_s), 32'(m_valid));
    check("rsp_data_s", 32'(rsp_data_s), 32'(m_data));
    check("xfer_cnt_s", 32'(xfer_cnt_s), 32'((m_cnt > 15) ? 15 : m_cnt));
  endtask

  task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] d, input logic rr);
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    rsp_ready = rr;
    step();
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  logic [NREQ*DW-1:0] ramp;
  logic [DW-1:0] exp_seq [NREQ];
  logic [NREQ-1:0] v;
  logic [NREQ*DW-1:0] d;

  initial begin
    req_data = '0;
    max_wait = 0;
    do_reset();

    // Reset state
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);

    // 1: single request from requester 0
    drive(4'b0001, 32'h0000_0001, 1'b1);
    check("t1_data", 32'(rsp_data), 32'h80);
    check("t1_id", 32'(rsp_id), 32'd0);
    check("t1_cnt", 32'(xfer_cnt), 32'd1);

    // 2: all valid, strict rotation 0,1,2,3,...
    do_reset();
    ramp = 32'h783C_1E0F;
    exp_seq[0] = 8'hF0; exp_seq[1] = 8'h78; exp_seq[2] = 8'h3C; exp_seq[3] = 8'h1E;
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, ramp, 1'b1);
      check("t2_id", 32'(rsp_id), 32'(i % NREQ));
      check("t2_data", 32'(rsp_data), 32'(exp_seq[i % NREQ]));
    end

    // 3: backpressure holds the slot and blocks all grants
    do_reset();
    drive(4'b0001, 32'h0000_0003, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(4'b0110, 32'h0022_1100, 1'b0);
      check("t3_hold_data", 32'(rsp_data), 32'hC0);
      check("t3_no_ready", 32'(req_ready), 32'd0);
    end
    drive(4'b0110, 32'h0022_1100, 1'b1);
    check("t3_next_id", 32'(rsp_id), 32'd1);

    // 4: lone requester 3 wins through the wrap-around search
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(4'b1000, 32'hE000_0000, 1'b1);
      check("t4_data", 32'(rsp_data), 32'h07);
      check("t4_id", 32'(rsp_id), 32'd3);
    end

    // 5: narrow counter saturates
    do_reset();
    for (int i = 0; i < 20; i++) drive(4'b1111, $urandom, 1'b1);
    check("t5_sat", 32'(xfer_cnt_s), 32'hF);
    check("t5_wide", 32'(xfer_cnt), 32'd20);

    // 6: async reset while FULL discards the slot immediately
    do_reset();
    drive(4'b1111, $urandom, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_drop", 32'(rsp_valid), 32'd0);
    check("t6_drop_s", 32'(rsp_valid_s), 32'd0);
    do_reset();
    drive(4'b1111, $urandom, 1'b1);
    check("t6_first_id", 32'(rsp_id), 32'd0);

    // Random traffic; pending requests hold data, may be withdrawn
    do_reset();
    max_wait = 0;
    v = '0;
    d = '0;
    for (int n = 0; n < 200; n++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (v[k] && !last_acc[k]) begin
          v[k] = ($urandom_range(7) != 0);
        end else begin
          v[k] = $urandom_range(1);
          d[k*DW +: DW] = DW'($urandom);
        end
      end
      drive(v, d, ($urandom_range(3) != 0));
    end
    check("max_wait_ok", 32'(max_wait <= NREQ-1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
